// File: rtl/caesar_pkg.sv
// caesar_pkg: shared constants, types and the mod-26 key subtraction used by
// the Caesar receive datapath (and a future encrypt-side counterpart).
//   SYM_W/KEY_W : symbol and key widths
//   ALPHA       : alphabet size and modulus
//   KEY_MAX     : largest legal key, also the largest legal letter index
//   sym_t/key_t : symbol and key types
//   fifo_word_t : one buffered output entry, {err, sym}
package caesar_pkg;

  localparam int unsigned SYM_W   = 32'd6;
  localparam int unsigned KEY_W   = 32'd5;
  localparam int unsigned ALPHA   = 32'd26;
  localparam int unsigned KEY_MAX = 32'd25;

  typedef logic [SYM_W-1:0] sym_t;
  typedef logic [KEY_W-1:0] key_t;

  typedef struct packed {
    logic err;
    sym_t sym;
  } fifo_word_t;

  // Legal letter indices and legal keys share the same upper bound.
  localparam sym_t SYM_MAX     = sym_t'(KEY_MAX);
  localparam key_t KEY_MAX_VAL = key_t'(KEY_MAX);

  // (sym - key) mod ALPHA for a legal letter index. The sum is formed one
  // bit wider than a symbol so sym + ALPHA cannot overflow before truncation.
  function automatic sym_t caesar_sub(input sym_t sym, input key_t key);
    logic [SYM_W:0] wide_sym_s;
    logic [SYM_W:0] wide_key_s;
    logic [SYM_W:0] diff_s;
    wide_sym_s = {1'b0, sym};
    wide_key_s = {{(SYM_W - KEY_W + 1){1'b0}}, key};
    if (wide_sym_s >= wide_key_s) begin
      diff_s = wide_sym_s - wide_key_s;
    end else begin
      diff_s = wide_sym_s + (SYM_W + 1)'(ALPHA) - wide_key_s;
    end
    return diff_s[SYM_W-1:0];
  endfunction

endpackage

// File: rtl/caesar_sym_fifo2.sv
// caesar_sym_fifo2: two-entry FIFO of {err, sym} words. slot0_r is always the
// head, so the output is taken straight from a register.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and data (ignored when full, unless popping)
//   pop, dout  : read request (ignored when empty) and head data
//   full/empty : occupancy == 2 / occupancy == 0
//   occupancy  : number of stored entries, 0..2
module caesar_sym_fifo2
  import caesar_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fifo_word_t din,
  input  logic       pop,
  output fifo_word_t dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] occupancy
);

  fifo_word_t slot0_r;
  fifo_word_t slot1_r;
  logic [1:0] count_r;
  logic       push_ok_s;
  logic       pop_ok_s;

  // Qualify requests: a pop frees the slot a simultaneous push needs.
  always_comb begin
    pop_ok_s  = pop && (count_r != 2'd0);
    push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
  end

  // Storage and occupancy update, including the simultaneous push/pop case.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_r <= '0;
      slot1_r <= '0;
      count_r <= 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            slot0_r <= din;
          end else begin
            slot1_r <= din;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          slot0_r <= slot1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind the survivor.
          if (count_r == 2'd1) begin
            slot0_r <= din;
          end else begin
            slot0_r <= slot1_r;
            slot1_r <= din;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign dout      = slot0_r;
  assign full      = (count_r == 2'd2);
  assign empty     = (count_r == 2'd0);
  assign occupancy = count_r;

endmodule

// File: rtl/caesar_stream_decrypt.sv
// caesar_stream_decrypt: receive side of the Caesar datapath. Cipher letter
// indices arrive on a valid/ready stream, have the current key subtracted
// mod 26 and leave through a 2-entry buffer on a second valid/ready stream.
//   CLOCK_50, rst          : clock, synchronous active-high reset
//   key_load, key_in       : key update strobe and value (0..25 accepted)
//   s_valid/s_ready/s_data : cipher symbol input stream
//   m_valid/m_ready/m_data : plaintext output stream
//   m_err                  : current m_data came from an out-of-range symbol
//   key_cur                : key in force; key_err pulses on a rejected load
//   sym_count, err_count   : saturating output-transfer / bad-symbol counters
module caesar_stream_decrypt
  import caesar_pkg::*;
#(
  parameter int unsigned CNT_W = 32'd8
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [SYM_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [SYM_W-1:0] m_data,
  output logic             m_err,
  output logic [KEY_W-1:0] key_cur,
  output logic             key_err,
  output logic [CNT_W-1:0] sym_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  key_t             key_cur_r;
  logic             key_err_r;
  logic [CNT_W-1:0] sym_count_r;
  logic [CNT_W-1:0] err_count_r;

  logic             in_fire_s;
  logic             out_fire_s;
  logic             pop_s;
  logic             sym_bad_s;
  logic             key_bad_s;
  fifo_word_t       dec_word_s;
  fifo_word_t       head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [1:0]       fifo_occ_s;

  // Handshake qualifiers; s_ready comes from the FIFO count register only.
  always_comb begin
    s_ready    = !fifo_full_s;
    m_valid    = (fifo_occ_s != 2'd0);
    in_fire_s  = s_valid && s_ready;
    pop_s      = m_ready && !fifo_empty_s;
    out_fire_s = m_valid && m_ready;
  end

  // Decode with the key in force at acceptance; bad symbols pass through.
  always_comb begin
    sym_bad_s  = (s_data > SYM_MAX);
    key_bad_s  = (key_in > KEY_MAX_VAL);
    dec_word_s = '0;
    if (sym_bad_s) begin
      dec_word_s.err = 1'b1;
      dec_word_s.sym = s_data;
    end else begin
      dec_word_s.err = 1'b0;
      dec_word_s.sym = caesar_sub(s_data, key_cur_r);
    end
  end

  // Key register and the one-cycle rejection pulse.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      key_cur_r <= '0;
      key_err_r <= 1'b0;
    end else begin
      key_err_r <= key_load && key_bad_s;
      if (key_load && !key_bad_s) begin
        key_cur_r <= key_in;
      end else begin
        key_cur_r <= key_cur_r;
      end
    end
  end

  // Saturating statistics counters for the display path.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sym_count_r <= '0;
      err_count_r <= '0;
    end else begin
      if (out_fire_s && (sym_count_r != CNT_MAX)) begin
        sym_count_r <= sym_count_r + CNT_ONE;
      end else begin
        sym_count_r <= sym_count_r;
      end
      if (in_fire_s && sym_bad_s && (err_count_r != CNT_MAX)) begin
        err_count_r <= err_count_r + CNT_ONE;
      end else begin
        err_count_r <= err_count_r;
      end
    end
  end

  caesar_sym_fifo2 u_fifo (
    .clk       (CLOCK_50),
    .rst       (rst),
    .push      (in_fire_s),
    .din       (dec_word_s),
    .pop       (pop_s),
    .dout      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .occupancy (fifo_occ_s)
  );

  assign m_data    = head_s.sym;
  assign m_err     = head_s.err;
  assign key_cur   = key_cur_r;
  assign key_err   = key_err_r;
  assign sym_count = sym_count_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_caesar_stream_decrypt.sv
// Self-checking bench for caesar_stream_decrypt: a vector table plus
// hand-written backpressure/reset sequences, with a scoreboard queue of
// expected {err, sym} words compared whenever an output transfer happens.
module tb_caesar_stream_decrypt;
  import caesar_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       rst;
  logic       key_load;
  key_t       key_in;
  logic       s_valid;
  logic       s_ready;
  sym_t       s_data;
  logic       m_valid;
  logic       m_ready;
  sym_t       m_data;
  logic       m_err;
  key_t       key_cur;
  logic       key_err;
  logic [7:0] sym_count;
  logic [7:0] err_count;

  int         total = 0;
  int         bad = 0;
  logic [6:0] q[$];
  int         exp_sym = 0;
  int         exp_err = 0;
  int         mkey = 0;
  bit         rand_rdy = 1'b0;

  typedef struct {
    bit   load;
    int   key;
    int   sym;
    int   exp;
    logic err;
  } vec_t;
  vec_t vecs[13];

  caesar_stream_decrypt dut (
    .CLOCK_50 (CLOCK_50), .rst (rst), .key_load (key_load), .key_in (key_in),
    .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data),
    .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data), .m_err (m_err),
    .key_cur (key_cur), .key_err (key_err),
    .sym_count (sym_count), .err_count (err_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [6:0] exp_of(input int sym, input int key);
    if (sym > 25) return {1'b1, 6'(sym)};
    else return {1'b0, 6'((sym - key + 26) % 26)};
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called with inputs stable after a falling edge: compare any output
  // transfer about to happen, then advance to the next falling edge.
  task automatic tick();
    logic [6:0] e;
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got data %0d with nothing expected", m_data);
      end else begin
        e = q.pop_front();
        check("sb_data", 32'(m_data), 32'(e[5:0]));
        check("sb_err", 32'(m_err), 32'(e[6]));
      end
    end
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int sym, input logic [6:0] exp);
    bit got;
    s_valid = 1'b1;
    s_data  = 6'(sym);
    for (int n = 0; n < 30; n++) begin
      got = (s_ready === 1'b1);
      if (got) begin
        q.push_back(exp);
        exp_sym++;
        if (exp[6]) exp_err++;
      end
      tick();
      if (got) return;
    end
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_key(input int k);
    s_valid  = 1'b0;
    key_load = 1'b1;
    key_in   = 5'(k);
    tick();
    key_load = 1'b0;
    if (k <= 25) mkey = k;
  endtask

  task automatic drain();
    s_valid = 1'b0;
    for (int n = 0; n < 60 && q.size() > 0; n++) tick();
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1,  3,  0, 23, 1'b0};
    vecs[1]  = '{1'b0,  3,  2, 25, 1'b0};
    vecs[2]  = '{1'b0,  3,  3,  0, 1'b0};
    vecs[3]  = '{1'b0,  3, 25, 22, 1'b0};
    vecs[4]  = '{1'b1,  4, 30, 30, 1'b1};
    vecs[5]  = '{1'b0,  4, 63, 63, 1'b1};
    vecs[6]  = '{1'b0,  4,  4,  0, 1'b0};
    vecs[7]  = '{1'b1, 25,  0,  1, 1'b0};
    vecs[8]  = '{1'b0, 25, 24, 25, 1'b0};
    vecs[9]  = '{1'b1, 13, 13,  0, 1'b0};
    vecs[10] = '{1'b0, 13, 12, 25, 1'b0};
    vecs[11] = '{1'b1,  0, 26, 26, 1'b1};
    vecs[12] = '{1'b1,  3,  7,  4, 1'b0};

    rst = 1'b1; key_load = 1'b0; key_in = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    @(negedge CLOCK_50);
    tick();
    tick();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_err", 32'(m_err), 32'd0);
    check("rst_key_cur", 32'(key_cur), 32'd0);
    check("rst_key_err", 32'(key_err), 32'd0);
    check("rst_sym_count", 32'(sym_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Key 0: every letter passes unchanged, one per cycle.
    m_ready = 1'b1;
    for (int i = 0; i < 26; i++) send(i, {1'b0, 6'(i)});
    drain();
    check("pass_sym_count", 32'(sym_count), 32'd26);
    check("pass_err_count", 32'(err_count), 32'd0);

    // Vector table: key loads, wrap-around, invalid symbols.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].load) load_key(vecs[i].key);
      send(vecs[i].sym, {vecs[i].err, 6'(vecs[i].exp)});
    end
    drain();
    check("tbl_sym_count", 32'(sym_count), 32'(sat(exp_sym)));
    check("tbl_err_count", 32'(err_count), 32'(sat(exp_err)));

    // Rejected key load.
    check("kerr_key_before", 32'(key_cur), 32'd3);
    key_load = 1'b1; key_in = 5'd26;
    tick();
    check("kerr_pulse", 32'(key_err), 32'd1);
    check("kerr_key_kept", 32'(key_cur), 32'd3);
    key_load = 1'b0;
    tick();
    check("kerr_pulse_end", 32'(key_err), 32'd0);
    send(5, {1'b0, 6'd2});
    check("latency_m_valid", 32'(m_valid), 32'd1);
    drain();

    // Backpressure, with a key load on the cycle 11 is accepted.
    m_ready = 1'b0;
    send(10, exp_of(10, 3));
    check("bp_head_valid", 32'(m_valid), 32'd1);
    key_load = 1'b1; key_in = 5'd7;
    send(11, exp_of(11, 3));
    key_load = 1'b0; mkey = 7;
    s_data = 6'd12;
    for (int i = 0; i < 3; i++) begin
      check("bp_s_ready_low", 32'(s_ready), 32'd0);
      check("bp_m_valid_hold", 32'(m_valid), 32'd1);
      check("bp_m_data_hold", 32'(m_data), 32'd7);
      tick();
    end
    check("bp_key_cur", 32'(key_cur), 32'd7);
    m_ready = 1'b1;
    send(12, exp_of(12, 7));
    drain();
    check("bp_sym_count", 32'(sym_count), 32'(sat(exp_sym)));

    // Random keys, symbols and backpressure against the arithmetic model.
    rand_rdy = 1'b1;
    for (int b = 0; b < 10; b++) begin
      load_key(int'($urandom_range(0, 25)));
      for (int i = 0; i < 20; i++) begin
        int sym;
        sym = int'($urandom_range(0, 63));
        send(sym, exp_of(sym, mkey));
      end
    end
    rand_rdy = 1'b0;
    m_ready = 1'b1;
    drain();
    check("rnd_sym_count", 32'(sym_count), 32'(sat(exp_sym)));
    check("rnd_err_count", 32'(err_count), 32'(sat(exp_err)));

    // Reset with two symbols buffered under backpressure.
    load_key(7);
    m_ready = 1'b0;
    send(1, exp_of(1, 7));
    send(2, exp_of(2, 7));
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("mrst_m_valid", 32'(m_valid), 32'd0);
    check("mrst_s_ready", 32'(s_ready), 32'd1);
    check("mrst_sym_count", 32'(sym_count), 32'd0);
    check("mrst_err_count", 32'(err_count), 32'd0);
    check("mrst_key_cur", 32'(key_cur), 32'd0);
    rst = 1'b0;
    q.delete();
    exp_sym = 0; exp_err = 0; mkey = 0;
    m_ready = 1'b1;
    send(9, {1'b0, 6'd9});
    drain();
    check("mrst_sym_after", 32'(sym_count), 32'd1);

    // Counter saturation with a long run of invalid symbols.
    for (int i = 0; i < 260; i++) send(26 + (i % 38), exp_of(26 + (i % 38), mkey));
    drain();
    check("sat_err_count", 32'(err_count), 32'd255);
    check("sat_sym_count", 32'(sym_count), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/caesar_stream_decrypt.md
Name: caesar_stream_decrypt

Overview:
- Receive side of the Caesar datapath. Accepts a stream of cipher letter indices (0..25, 6-bit) over a valid/ready handshake.
- Subtracts a loadable key mod 26 and emits plaintext indices over a second valid/ready handshake.
- Carries a 2-entry output buffer, so full throughput holds under backpressure.
- Flags out-of-range symbols and invalid key loads, and keeps saturating symbol/error counters for the 7-seg display path.

Parameters:
- SYM_W, 6, symbol width (letter index 0..25; codes 26..63 are invalid).
- KEY_W, 5, key width (legal keys 0..25).
- ALPHA, 26, alphabet size / modulus.
- CNT_W, 8, width of the statistics counters.

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- key_load  in  1  strobe: sample key_in this cycle.
- key_in  in  KEY_W  new key value.
- s_valid  in  1  input symbol valid.
- s_ready  out  1  block can accept an input symbol.
- s_data  in  SYM_W  cipher symbol.
- m_valid  out  1  output symbol valid.
- m_ready  in  1  downstream accepts the output symbol.
- m_data  out  SYM_W  plaintext symbol.
- m_err  out  1  the current m_data came from an invalid input symbol.
- key_cur  out  KEY_W  key currently in force.
- key_err  out  1  one-cycle pulse when key_load is rejected.
- sym_count  out  CNT_W  output handshakes completed, saturating.
- err_count  out  CNT_W  invalid symbols accepted at input, saturating.

Behaviour:
- Reset values:
  - key_cur=0, m_valid=0, m_data=0, m_err=0, key_err=0, sym_count=0, err_count=0.
  - Buffer empty, so s_ready=1 in the first cycle after reset.
- Reset asserted mid-stream flushes the buffer; buffered symbols are lost and are not counted.
- Handshakes:
  - Input transfer = s_valid&&s_ready. Output transfer = m_valid&&m_ready.
  - s_ready = (occupancy<2) and depends only on registered state; there is no combinational path from m_ready.
  - m_valid = (occupancy>0). m_data/m_err come from the head entry and stay stable while m_valid&&!m_ready.
- Latency: a symbol accepted at edge N is presented with m_valid=1 in the cycle after edge N.
- Throughput: with m_ready held high, 1 symbol/cycle sustained.
- Simultaneous push and pop: occupancy is unchanged, order is preserved, and this is legal even when occupancy=2 (the pop frees the slot; s_ready is still 0 that cycle, so no push happens).
- Arithmetic, applied at input acceptance using key_cur:
  - s_data<=25: out = (s_data>=key) ? s_data-key : s_data+ALPHA-key, computed at SYM_W+1 bits and then truncated.
  - s_data>25: out = s_data unchanged, err bit=1, err_count+=1 (saturates at 2^CNT_W-1).
- Key load:
  - key_in<=25: key_cur=key_in from the next cycle.
  - key_in>25: key_cur unchanged, key_err=1 for exactly one cycle.
  - key_load in the same cycle as an input transfer: that symbol uses the OLD key. Symbols already buffered keep the key they were decoded with.
- sym_count increments on each output transfer and saturates at 2^CNT_W-1 with no wrap.
- Combined example: at err_count=255 with an invalid symbol accepted, err_count stays 255 and m_err is still set.

Decomposition:
- Package caesar_pkg holds:
  - constants ALPHA=26, SYM_W=6, KEY_W=5, KEY_MAX=25;
  - typedefs sym_t (SYM_W bits), key_t (KEY_W bits);
  - function caesar_sub(sym_t, key_t) returning sym_t, shared with a future encrypt-side counterpart.
- One sub-module, caesar_sym_fifo2: a 2-entry FIFO of {err, sym}. It has push/pop, full/empty and occupancy outputs, a synchronous active-high rst, and supports simultaneous push and pop.
- The top level holds key_cur, validation, the decode function and the counters.

Test Plan:
- Reset, then idle: all outputs 0 except s_ready=1; key_cur=0; symbols 0..25 pass unchanged, 1-cycle latency, sym_count=26.
- key_load key_in=3, stream 0,2,3,25 with m_ready=1 -> m_data 23,25,0,22 on consecutive cycles, m_err=0, sym_count=4.
- key_load key_in=26 while key_cur=3 -> key_err pulses for 1 cycle; key_cur stays 3; next symbol 5 -> 2.
- Invalid symbols: with key 4, input 30 -> m_data=30, m_err=1, err_count=1; then 63 -> err_count=2; then 4 -> m_data=0, m_err=0.
- Backpressure and key timing:
  - m_ready=0, offer 10,11,12 -> exactly 2 accepted, then s_ready=0 and m_data holds the first decode.
  - key_load 7 in the same cycle 11 is accepted -> 11 decodes with the old key, 12 decodes with 7 (12->5).
  - Release m_ready -> outputs appear in order, no loss and no duplicate.
- Reset asserted with 2 symbols buffered and m_ready=0 -> next cycle m_valid=0, s_ready=1, counters=0, key_cur=0.
